// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/PPU memory arbiter.
// Statistics counters are built only with MEM_ARB_STATS_EN defined.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_PPU = 1'b1;

  localparam int CNT_W  = 16;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

endpackage

// File: rtl/mem_arb_sat_counter.sv
// Saturating event counter used by the arbiter statistics.
// Instantiated only when MEM_ARB_STATS_EN is defined.
module mem_arb_sat_counter
  import mem_arb_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// CPU/PPU shared-memory arbiter: PPU priority with bounded CPU starvation.
// Define MEM_ARB_STATS_EN to add grant and stall statistics outputs.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT        = 2,
  parameter int MAX_PPU_BURST = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_done,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ppu_req,
  input  logic              ppu_we,
  input  logic [ADDR_W-1:0] ppu_addr,
  input  logic [DATA_W-1:0] ppu_wdata,
  output logic              ppu_ack,
  output logic              ppu_rvalid,
  output logic [DATA_W-1:0] ppu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_cpu,
  output logic              mem_rd_ppu,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q_cpu,
  input  logic [DATA_W-1:0] mem_q_ppu
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  cpu_grants,
  output logic [CNT_W-1:0]  ppu_grants,
  output logic [CNT_W-1:0]  cpu_stall_cycles
`endif
);

  arb_state_t state;
  logic       owner;
  logic       is_read;
  logic [2:0] wait_cnt;
  logic [3:0] ppu_streak;

  acc_t cpu_acc;
  acc_t ppu_acc;
  acc_t win_acc;
  logic ppu_first;
  logic grant_cpu;
  logic grant_ppu;

  assign cpu_acc = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign ppu_acc = '{we: ppu_we, addr: ppu_addr, wdata: ppu_wdata};

  // PPU wins unless a waiting CPU has already sat out a full burst.
  always_comb begin
    ppu_first = ppu_req &&
      !(cpu_req && (ppu_streak == 4'(MAX_PPU_BURST)));
    grant_ppu = 1'b0;
    grant_cpu = 1'b0;
    if ((state == ST_IDLE) && load_done) begin
      grant_ppu = ppu_first;
      grant_cpu = cpu_req && !ppu_first;
    end
    win_acc = grant_ppu ? ppu_acc : cpu_acc;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      owner      <= REQ_CPU;
      is_read    <= 1'b0;
      wait_cnt   <= '0;
      ppu_streak <= '0;
      mem_addr   <= '0;
      mem_d      <= '0;
      mem_rd_cpu <= 1'b0;
      mem_rd_ppu <= 1'b0;
      mem_wr     <= 1'b0;
      cpu_ack    <= 1'b0;
      ppu_ack    <= 1'b0;
      cpu_rvalid <= 1'b0;
      ppu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      ppu_rdata  <= '0;
    end else begin
      mem_rd_cpu <= 1'b0;
      mem_rd_ppu <= 1'b0;
      mem_wr     <= 1'b0;
      cpu_ack    <= 1'b0;
      ppu_ack    <= 1'b0;
      cpu_rvalid <= 1'b0;
      ppu_rvalid <= 1'b0;

      if (!cpu_req || grant_cpu) begin
        ppu_streak <= '0;
      end else if (grant_ppu) begin
        ppu_streak <= ppu_streak + 4'd1;
      end

      unique case (state)
        ST_IDLE: begin
          if (grant_cpu || grant_ppu) begin
            state      <= ST_ISSUE;
            owner      <= grant_ppu ? REQ_PPU : REQ_CPU;
            is_read    <= !win_acc.we;
            mem_addr   <= win_acc.addr;
            mem_d      <= win_acc.wdata;
            mem_wr     <= win_acc.we;
            mem_rd_cpu <= grant_cpu && !win_acc.we;
            mem_rd_ppu <= grant_ppu && !win_acc.we;
            cpu_ack    <= grant_cpu;
            ppu_ack    <= grant_ppu;
          end
        end
        ST_ISSUE: begin
          state    <= is_read ? ST_WAIT : ST_IDLE;
          wait_cnt <= 3'(RD_LAT - 1);
        end
        ST_WAIT: begin
          if (wait_cnt == 3'd0) begin
            state <= ST_IDLE;
            if (owner == REQ_PPU) begin
              ppu_rdata  <= mem_q_ppu;
              ppu_rvalid <= 1'b1;
            end else begin
              cpu_rdata  <= mem_q_cpu;
              cpu_rvalid <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  mem_arb_sat_counter #(.W(CNT_W)) u_cpu_grants (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (grant_cpu),
    .count   (cpu_grants)
  );

  mem_arb_sat_counter #(.W(CNT_W)) u_ppu_grants (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (grant_ppu),
    .count   (ppu_grants)
  );

  mem_arb_sat_counter #(.W(CNT_W)) u_cpu_stall (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (cpu_req && !cpu_ack),
    .count   (cpu_stall_cycles)
  );
`endif

endmodule
